wb_arbiter2: RTL and testbench

Two-initiator Wishbone classic arbiter that shares a single 30-bit word-addressed, 32-bit data bus between the Sentinel core (`m0`) and a secondary initiator (`m1`, e.g. a debug or DMA engine). Grants are registered, round-robin, and held for the full duration of the winning initiator's `cyc`. An optional watchdog terminates target cycles that never acknowledge, so a hung peripheral cannot stall the core indefinitely. The block sits between the initiators and the system interconnect.

---
 rtl/wb_arbiter2.sv | 212 +++++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
//
// Two-initiator Wishbone classic arbiter. Shares one 30-bit word-addressed,
// 32-bit data target bus between the core (m0) and a secondary initiator (m1).
// Ownership is granted round-robin, registered, and held for the entire
// duration of the winner's cyc. While owned, the request path (adr, sel, we,
// dat_w, stb, cyc) and the response path (ack, dat_r) are combinational
// copies, so no latency is added to a transfer.
//
// Optional watchdog, enabled by defining WB_ARB_WATCHDOG_EN:
//   - A target that leaves s__stb unacknowledged for more than TIMEOUT cycles
//     is cut off.
//   - The owner then receives a one-cycle err pulse.
//   - The bus stays parked until the owner drops cyc.
// Without the macro TIMEOUT has no effect, there is no ABORT state, and
// both err outputs are tied to 0.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   m0__* / m1__*  (in)        adr[29:0], cyc, stb, we, sel[3:0], dat_w[31:0]
//   m0__* / m1__*  (out)       dat_r[31:0], ack, err
//   s__*           (out)       adr[29:0], cyc, stb, we, sel[3:0], dat_w[31:0]
//   s__dat_r, s__ack (in)      target read data and acknowledge
//   grant[1:0]     (out)       one-hot owner: 01 = m0, 10 = m1, 00 = none
// ---------------------------------------------------------------------------
module wb_arbiter2 #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [29:0] m0__adr,
   input  logic        m0__cyc,
   input  logic        m0__stb,
   input  logic        m0__we,
   input  logic [3:0]  m0__sel,
   input  logic [31:0] m0__dat_w,
   output logic [31:0] m0__dat_r,
   output logic        m0__ack,
   output logic        m0__err,

   input  logic [29:0] m1__adr,
   input  logic        m1__cyc,
   input  logic        m1__stb,
   input  logic        m1__we,
   input  logic [3:0]  m1__sel,
   input  logic [31:0] m1__dat_w,
   output logic [31:0] m1__dat_r,
   output logic        m1__ack,
   output logic        m1__err,

   output logic [29:0] s__adr,
   output logic        s__cyc,
   output logic        s__stb,
   output logic        s__we,
   output logic [3:0]  s__sel,
   output logic [31:0] s__dat_w,
   input  logic [31:0] s__dat_r,
   input  logic        s__ack,

   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
`ifdef WB_ARB_WATCHDOG_EN
      OWN1  = 2'd2,
      ABORT = 2'd3
`else
      OWN1  = 2'd2
`endif
   } state_t;

   state_t state;

   // Most recently granted initiator (0 = m0, 1 = m1). While a bus is owned
   // (or being aborted) this is also the current owner, because every grant
   // updates it.
   logic last;

`ifdef WB_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd;
   logic            errPulse;
`endif

   logic ownerCyc;
   logic otherCyc;
   logic idlePick;

   assign ownerCyc = last ? m1__cyc : m0__cyc;
   assign otherCyc = last ? m0__cyc : m1__cyc;
   // On a tie the initiator that was not granted last wins.
   // Otherwise the single requester wins.
   assign idlePick = (m0__cyc && m1__cyc) ? ~last : m1__cyc;

   // Registered arbitration state, priority pointer, grant and watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         grant <= 2'b00;
`ifdef WB_ARB_WATCHDOG_EN
         wd       <= '0;
         errPulse <= 1'b0;
`endif
      end else begin
`ifdef WB_ARB_WATCHDOG_EN
         errPulse <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (m0__cyc || m1__cyc) begin
                  state <= idlePick ? OWN1 : OWN0;
                  last  <= idlePick;
                  grant <= idlePick ? 2'b10 : 2'b01;
`ifdef WB_ARB_WATCHDOG_EN
                  wd    <= '0;
`endif
               end
            end

            OWN0, OWN1
`ifdef WB_ARB_WATCHDOG_EN
            , ABORT
`endif
            : begin
               // Releasing hands straight over to a waiting initiator, so a
               // released owner can never jump back ahead of the other side.
               if (!ownerCyc) begin
                  if (otherCyc) begin
                     state <= last ? OWN0 : OWN1;
                     last  <= ~last;
                     grant <= last ? 2'b01 : 2'b10;
`ifdef WB_ARB_WATCHDOG_EN
                     wd    <= '0;
`endif
                  end else begin
                     state <= IDLE;
                     grant <= 2'b00;
                  end
               end
`ifdef WB_ARB_WATCHDOG_EN
               else if (state != ABORT) begin
                  // An ack in the cycle the limit is reached still wins.
                  if (s__stb && !s__ack) begin
                     if (wd == WD_W'(TIMEOUT)) begin
                        state    <= ABORT;
                        errPulse <= 1'b1;
                     end else begin
                        wd <= wd + WD_W'(1);
                     end
                  end else begin
                     wd <= '0;
                  end
               end
`endif
            end

            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

   // The bus is routed only while in OWN0/OWN1. IDLE and ABORT leave every
   // target output at 0 and drop any stray ack on the floor.
   always_comb begin
      s__adr    = '0;
      s__cyc    = 1'b0;
      s__stb    = 1'b0;
      s__we     = 1'b0;
      s__sel    = '0;
      s__dat_w  = '0;
      m0__ack   = 1'b0;
      m0__dat_r = '0;
      m1__ack   = 1'b0;
      m1__dat_r = '0;
      if (state == OWN0) begin
         s__adr    = m0__adr;
         s__cyc    = m0__cyc;
         s__stb    = m0__stb;
         s__we     = m0__we;
         s__sel    = m0__sel;
         s__dat_w  = m0__dat_w;
         m0__ack   = s__ack;
         m0__dat_r = s__dat_r;
      end else if (state == OWN1) begin
         s__adr    = m1__adr;
         s__cyc    = m1__cyc;
         s__stb    = m1__stb;
         s__we     = m1__we;
         s__sel    = m1__sel;
         s__dat_w  = m1__dat_w;
         m1__ack   = s__ack;
         m1__dat_r = s__dat_r;
      end
   end

`ifdef WB_ARB_WATCHDOG_EN
   assign m0__err = errPulse & ~last;
   assign m1__err = errPulse &  last;
`else
   assign m0__err = 1'b0;
   assign m1__err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2
//
// Directed scenarios followed by a randomized phase. All outputs are checked
// every cycle against a behavioural owner/priority model. Extra constant
// checks cover the key timing points of each scenario.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] m0__adr, m1__adr, s__adr;
   logic        m0__cyc, m0__stb, m0__we, m1__cyc, m1__stb, m1__we;
   logic [3:0]  m0__sel, m1__sel, s__sel;
   logic [31:0] m0__dat_w, m1__dat_w, m0__dat_r, m1__dat_r, s__dat_w, s__dat_r;
   logic        m0__ack, m0__err, m1__ack, m1__err;
   logic        s__cyc, s__stb, s__we, s__ack;
   logic [1:0]  grant;

   int total = 0;
   int bad   = 0;

   // Reference model: current owner (-1 = none), priority pointer,
   // abort flag, and pending err pulse.
   int   mOwner;
   logic mLast;
   logic mAbort;
   logic mErr;
   int   mStall;

   wb_arbiter2 #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0__adr(m0__adr), .m0__cyc(m0__cyc), .m0__stb(m0__stb), .m0__we(m0__we),
      .m0__sel(m0__sel), .m0__dat_w(m0__dat_w), .m0__dat_r(m0__dat_r),
      .m0__ack(m0__ack), .m0__err(m0__err),
      .m1__adr(m1__adr), .m1__cyc(m1__cyc), .m1__stb(m1__stb), .m1__we(m1__we),
      .m1__sel(m1__sel), .m1__dat_w(m1__dat_w), .m1__dat_r(m1__dat_r),
      .m1__ack(m1__ack), .m1__err(m1__err),
      .s__adr(s__adr), .s__cyc(s__cyc), .s__stb(s__stb), .s__we(s__we),
      .s__sel(s__sel), .s__dat_w(s__dat_w), .s__dat_r(s__dat_r), .s__ack(s__ack),
      .grant(grant)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOwner = -1;
      mLast  = 1'b1;
      mAbort = 1'b0;
      mErr   = 1'b0;
      mStall = 0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic modelStep();
      logic [1:0] cyc;
      logic [1:0] stb;
      int   nOwner;
      logic nAbort;
      logic nErr;
      cyc    = {m1__cyc, m0__cyc};
      stb    = {m1__stb, m0__stb};
      nOwner = mOwner;
      nAbort = mAbort;
      nErr   = 1'b0;
      if (rst) begin
         modelReset();
      end else begin
         if (mOwner < 0) begin
            if (cyc == 2'b11) nOwner = mLast ? 0 : 1;
            else if (cyc[0])  nOwner = 0;
            else if (cyc[1])  nOwner = 1;
            if (nOwner >= 0) begin
               mLast  = nOwner[0];
               mStall = 0;
            end
         end else if (!cyc[mOwner]) begin
            nAbort = 1'b0;
            if (cyc[1 - mOwner]) begin
               nOwner = 1 - mOwner;
               mLast  = nOwner[0];
               mStall = 0;
            end else begin
               nOwner = -1;
            end
         end
`ifdef WB_ARB_WATCHDOG_EN
         else if (!mAbort) begin
            if (stb[mOwner] && !s__ack) begin
               if (mStall == TO) begin
                  nAbort = 1'b1;
                  nErr   = 1'b1;
               end else begin
                  mStall++;
               end
            end else begin
               mStall = 0;
            end
         end
`endif
         mOwner = nOwner;
         mAbort = nAbort;
         mErr   = nErr;
      end
   endtask

   task automatic applyStimulus(input logic c0, input logic s0, input logic w0,
                                input logic c1, input logic s1, input logic w1,
                                input logic ack, input logic [31:0] rdata);
      m0__cyc = c0; m0__stb = s0; m0__we = w0;
      m1__cyc = c1; m1__stb = s1; m1__we = w1;
      m0__adr = 30'($urandom); m1__adr = 30'($urandom);
      m0__sel = 4'($urandom);  m1__sel = 4'($urandom);
      m0__dat_w = $urandom;    m1__dat_w = $urandom;
      s__ack = ack;
      s__dat_r = rdata;
   endtask

   task automatic checkOutput(input string tag);
      logic [63:0] es, ed, e0, e1;
      logic [1:0]  eg;
      logic        bus;
      bus = (mOwner >= 0) && !mAbort;
      es = '0; ed = '0; e0 = '0; e1 = '0;
      eg = (mOwner == 0) ? 2'b01 : (mOwner == 1) ? 2'b10 : 2'b00;
      if (bus && mOwner == 0) begin
         es = {27'd0, m0__cyc, m0__stb, m0__we, m0__sel, m0__adr};
         ed = {32'd0, m0__dat_w};
         e0 = {30'd0, s__ack, 1'b0, s__dat_r};
      end else if (bus && mOwner == 1) begin
         es = {27'd0, m1__cyc, m1__stb, m1__we, m1__sel, m1__adr};
         ed = {32'd0, m1__dat_w};
         e1 = {30'd0, s__ack, 1'b0, s__dat_r};
      end
      e0[32] = mErr && (mOwner == 0);
      e1[32] = mErr && (mOwner == 1);
      checkEq({tag, ".grant"}, 64'(grant), 64'(eg));
      checkEq({tag, ".sbus"}, {27'd0, s__cyc, s__stb, s__we, s__sel, s__adr}, es);
      checkEq({tag, ".dat_w"}, 64'(s__dat_w), ed);
      checkEq({tag, ".m0"}, {30'd0, m0__ack, m0__err, m0__dat_r}, e0);
      checkEq({tag, ".m1"}, {30'd0, m1__ack, m1__err, m1__dat_r}, e1);
   endtask

   task automatic sampleCycle(input string tag);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic advanceCycle();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      modelReset();
      sampleCycle("reset");
      checkEq("reset.grant", 64'(grant), 64'd0);
      checkEq("reset.scyc", 64'(s__cyc), 64'd0);
      advanceCycle();
      rst = 1'b0;
   endtask

   // Directed scenarios from the test plan, then randomized traffic.
   initial begin
      int   beats;
      int   o;
      logic done;
      logic r0, r1;

      $display("[TB] start");
      #1;
      doReset();

      // m0 single read, m1 idle
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("m0rd.c1"); checkEq("m0rd.scyc_c1", 64'(s__cyc), 64'd0); advanceCycle();
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("m0rd.c2"); checkEq("m0rd.scyc_c2", 64'(s__cyc), 64'd1); advanceCycle();
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF);
      sampleCycle("m0rd.c3");
      checkEq("m0rd.dat_r", 64'(m0__dat_r), 64'hDEADBEEF);
      checkEq("m0rd.ack", 64'(m0__ack), 64'd1);
      checkEq("m0rd.m1ack", 64'(m1__ack), 64'd0);
      advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("m0rd.c4"); advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555AAAA);
      sampleCycle("m0rd.idle"); checkEq("m0rd.idle_grant", 64'(grant), 64'd0); advanceCycle();

      // Simultaneous first requests after reset
      doReset();
      applyStimulus(1, 1, 0, 1, 1, 0, 0, 32'h0);
      sampleCycle("tie.c1"); advanceCycle();
      applyStimulus(1, 1, 0, 1, 1, 0, 1, $urandom);
      sampleCycle("tie.c2"); checkEq("tie.first", 64'(grant), 64'b01); advanceCycle();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h0);
      sampleCycle("tie.c3"); checkEq("tie.hold", 64'(grant), 64'b01); advanceCycle();
      applyStimulus(0, 0, 0, 1, 1, 0, 1, $urandom);
      sampleCycle("tie.c4");
      checkEq("tie.handover", 64'(grant), 64'b10);
      checkEq("tie.handover_scyc", 64'(s__cyc), 64'd1);
      advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("tie.c5"); advanceCycle();

      // Both request continuously, one beat per ownership
      doReset();
      beats = 0;
      done  = 1'b0;
      for (int k = 0; k < 20 && beats < 4; k++) begin
         o = mOwner;
         applyStimulus(!(o == 0 && done), (o == 0 && !done), 1'b0,
                       !(o == 1 && done), (o == 1 && !done), 1'b1,
                       (o >= 0 && !done), $urandom);
         sampleCycle("alt");
         if (o >= 0) begin
            if (!done) begin
               checkEq($sformatf("alt.beat%0d", beats), 64'(grant),
                       (beats % 2 == 0) ? 64'b01 : 64'b10);
               beats++;
               done = 1'b1;
            end else begin
               done = 1'b0;
            end
         end
         advanceCycle();
      end
      checkEq("alt.beats", 64'(beats), 64'd4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("alt.end"); advanceCycle();

      // m0 keeps cyc across three beats while m1 waits
      doReset();
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 32'h0);
      sampleCycle("burst.c1"); advanceCycle();
      for (int j = 0; j < 6; j++) begin
         applyStimulus(1, (j % 2 == 0), 1'b1, 1, 0, 0, (j % 2 == 0), $urandom);
         sampleCycle("burst");
         checkEq($sformatf("burst.grant%0d", j), 64'(grant), 64'b01);
         advanceCycle();
      end
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
      sampleCycle("burst.drop"); checkEq("burst.drop_grant", 64'(grant), 64'b01); advanceCycle();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h0);
      sampleCycle("burst.m1"); checkEq("burst.m1_grant", 64'(grant), 64'b10); advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("burst.end"); advanceCycle();

`ifdef WB_ARB_WATCHDOG_EN
      // Watchdog: target never acks
      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wd.c1"); advanceCycle();
      for (int j = 2; j <= 6; j++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
         sampleCycle("wd.wait");
         checkEq($sformatf("wd.noerr_c%0d", j), 64'(m0__err), 64'd0);
         advanceCycle();
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wd.c7");
      checkEq("wd.err_c7", 64'(m0__err), 64'd1);
      checkEq("wd.scyc_c7", 64'(s__cyc), 64'd0);
      advanceCycle();
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h0);
      sampleCycle("wd.c8"); checkEq("wd.err_c8", 64'(m0__err), 64'd0); advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wd.c9"); advanceCycle();
      sampleCycle("wd.c10"); checkEq("wd.idle_grant", 64'(grant), 64'd0); advanceCycle();

      // Watchdog: ack arrives just in time
      doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wdok.c1"); advanceCycle();
      for (int j = 2; j <= 6; j++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, (j == 6), $urandom);
         sampleCycle("wdok.wait"); advanceCycle();
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wdok.c7");
      checkEq("wdok.err_c7", 64'(m0__err), 64'd0);
      checkEq("wdok.scyc_c7", 64'(s__cyc), 64'd1);
      advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("wdok.end"); advanceCycle();
`endif

      // Reset asserted during an m1 write
      doReset();
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 32'h0);
      sampleCycle("rstmid.c1"); advanceCycle();
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 32'h0);
      sampleCycle("rstmid.c2"); advanceCycle();
      applyStimulus(0, 0, 0, 1, 1, 1, 1, 32'h12345678);
      sampleCycle("rstmid.pre");
      checkEq("rstmid.pre_ack", 64'(m1__ack), 64'd1);
      #2 rst = 1'b1;
      #1;
      checkEq("rstmid.grant", 64'(grant), 64'd0);
      checkEq("rstmid.sbus", {27'd0, s__cyc, s__stb, s__we, s__sel, s__adr}, 64'd0);
      checkEq("rstmid.m1", {30'd0, m1__ack, m1__err, m1__dat_r}, 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1, 1, 0, 1, 1, 0, 0, 32'h0);
      sampleCycle("rstmid.tie1"); advanceCycle();
      applyStimulus(1, 1, 0, 1, 1, 0, 0, 32'h0);
      sampleCycle("rstmid.tie2"); checkEq("rstmid.tie_grant", 64'(grant), 64'b01); advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("rstmid.end"); advanceCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
      sampleCycle("rstmid.end2"); advanceCycle();

      // Randomized traffic against the model
      r0 = 1'b0;
      r1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) r0 = ~r0;
         if ($urandom_range(3) == 0) r1 = ~r1;
         applyStimulus(r0, 1'($urandom), 1'($urandom), r1, 1'($urandom), 1'($urandom),
                       1'($urandom), $urandom);
         sampleCycle("rand");
         advanceCycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
